// File: rtl/acc_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// acc_cpu_sequencer
// Multi-cycle fetch/wait/execute sequencer for the 8-bit accumulator core.
// Each instruction occupies three cycles: FETCH drives the program memory
// read, WAIT captures the returned word into the instruction register, and
// EXEC decodes it, strobes the datapath and advances the program counter.
// Datapath controls are combinational from state and ir so that an
// asynchronous reset removes any write strobe in the same instant.
// ---------------------------------------------------------------------------
module acc_cpu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] pmem_addr,
    output logic            pmem_en,
    input  logic [15:0]     pmem_rdata,
    input  logic            cy,
    input  logic            ov,
    input  logic            zf,
    input  logic            sf,
    output logic [2:0]      alu_op,
    output logic [7:0]      imm,
    output logic            acc_we,
    output logic            ce_cy,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_JCC  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     ir_r;
    logic            pmem_en_r;
    logic            halted_r;

    logic [3:0]      opcode_s;
    logic [3:0]      cond_s;
    logic            cond_true_s;
    logic [PC_W-1:0] target_s;
    logic [PC_W-1:0] pc_plus1_s;
    logic [PC_W-1:0] next_pc_s;
    logic [2:0]      alu_op_s;
    logic [7:0]      imm_s;
    logic            acc_we_s;
    logic            ce_cy_s;

    // Condition-code evaluation against the current flag inputs; 9-15 never taken.
    function automatic logic cond_eval(
        input logic [3:0] c,
        input logic       f_cy,
        input logic       f_ov,
        input logic       f_zf,
        input logic       f_sf
    );
        logic r;
        case (c)
            4'd0:    r = f_zf;
            4'd1:    r = ~f_zf;
            4'd2:    r = f_cy;
            4'd3:    r = ~f_cy;
            4'd4:    r = f_ov;
            4'd5:    r = ~f_ov;
            4'd6:    r = f_sf;
            4'd7:    r = ~f_sf;
            4'd8:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign opcode_s    = ir_r[15:12];
    assign cond_s      = ir_r[11:8];
    assign cond_true_s = cond_eval(cond_s, cy, ov, zf, sf);
    assign pc_plus1_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

    // The 8-bit target field is fitted to the program counter width.
    generate
        if (PC_W > 8) begin : g_tgt_wide
            assign target_s = {{(PC_W-8){1'b0}}, ir_r[7:0]};
        end else if (PC_W == 8) begin : g_tgt_same
            assign target_s = ir_r[7:0];
        end else begin : g_tgt_narrow
            assign target_s = ir_r[PC_W-1:0];
        end
    endgenerate

    // Program counter value committed at the end of EXEC.
    always_comb begin
        next_pc_s = pc_plus1_s;
        case (opcode_s)
            OP_JMP: next_pc_s = target_s;
            OP_JCC: begin
                if (cond_true_s) begin
                    next_pc_s = target_s;
                end else begin
                    next_pc_s = pc_plus1_s;
                end
            end
            default: next_pc_s = pc_plus1_s;
        endcase
    end

    // Datapath strobes decoded from ir, forced low outside EXEC.
    always_comb begin
        alu_op_s = 3'd0;
        imm_s    = 8'd0;
        acc_we_s = 1'b0;
        ce_cy_s  = 1'b0;
        if (state_r == ST_EXEC) begin
            imm_s = ir_r[7:0];
            case (opcode_s)
                OP_LDI: begin
                    alu_op_s = 3'd0;
                    acc_we_s = 1'b1;
                end
                OP_ADD: begin
                    alu_op_s = 3'd1;
                    acc_we_s = 1'b1;
                    ce_cy_s  = 1'b1;
                end
                OP_SUB: begin
                    alu_op_s = 3'd2;
                    acc_we_s = 1'b1;
                    ce_cy_s  = 1'b1;
                end
                OP_AND: begin
                    alu_op_s = 3'd3;
                    acc_we_s = 1'b1;
                end
                OP_OR: begin
                    alu_op_s = 3'd4;
                    acc_we_s = 1'b1;
                end
                OP_XOR: begin
                    alu_op_s = 3'd5;
                    acc_we_s = 1'b1;
                end
                OP_NOP: begin
                    alu_op_s = 3'd0;
                end
                default: begin
                    // JMP, JCC, HALT and reserved opcodes drive no strobes.
                    alu_op_s = 3'd0;
                end
            endcase
        end else begin
            imm_s = 8'd0;
        end
    end

    // Sequencer FSM with registered program-memory enable and halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            ir_r      <= 16'd0;
            pmem_en_r <= 1'b0;
            halted_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_r   <= ST_FETCH;
                        pmem_en_r <= 1'b1;
                        halted_r  <= 1'b0;
                    end else begin
                        pmem_en_r <= 1'b0;
                        halted_r  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_r   <= ST_WAIT;
                    pmem_en_r <= 1'b0;
                end
                ST_WAIT: begin
                    ir_r    <= pmem_rdata;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc_r <= next_pc_s;
                    if (opcode_s == OP_HALT) begin
                        state_r   <= ST_HALT;
                        pmem_en_r <= 1'b0;
                        halted_r  <= 1'b1;
                    end else begin
                        state_r   <= ST_FETCH;
                        pmem_en_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pmem_en_r <= 1'b0;
                    halted_r  <= 1'b1;
                end
            endcase
        end
    end

    assign pmem_addr = pc_r;
    assign pmem_en   = pmem_en_r;
    assign pc        = pc_r;
    assign halted    = halted_r;
    assign alu_op    = alu_op_s;
    assign imm       = imm_s;
    assign acc_we    = acc_we_s;
    assign ce_cy     = ce_cy_s;

endmodule
